// File: rtl/load_store_unit.sv
// load_store_unit: sequences one byte/halfword/word load or store against a
// word-wide, big-endian, byte-addressed data port. Sub-word stores use
// read-modify-write; sub-word loads are sign/zero extended.
// Optional feature macro: LSU_ALIGN_CHECK_EN (rejects misaligned half/word).
module load_store_unit #(
  parameter int unsigned MEM_SIZE = 65536
) (
  input  logic        mem_Clk,
  input  logic        mem_Rst,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_signed,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] lsu_rdata,
  output logic [31:0] data_memory_a,
  output logic        data_memory_read,
  output logic        data_memory_write,
  output logic [31:0] data_memory_out_v,
  input  logic [31:0] data_memory_in_v
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [1:0]  SZ_BYTE   = 2'b00;
  localparam logic [1:0]  SZ_HALF   = 2'b01;
  localparam logic [1:0]  SZ_WORD   = 2'b10;
  localparam logic [31:0] LAST_ADDR = 32'(MEM_SIZE - 4);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_bad;
  logic        misaligned;

  // Request validity: bounds (memory always touches 4 bytes), size, alignment.
  always_comb begin
    misaligned = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    misaligned = ((lsu_size == SZ_HALF) && lsu_addr[0]) ||
                 ((lsu_size == SZ_WORD) && (lsu_addr[1:0] != 2'b00));
`endif
    req_bad = (lsu_size == 2'b11) || (lsu_addr > LAST_ADDR) || misaligned;
  end

  // State and request registers; reset aborts any access in flight.
  always_ff @(posedge mem_Clk or posedge mem_Rst) begin
    if (mem_Rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic, load extraction and store merge.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (lsu_req) begin
          we_d    = lsu_we;
          size_d  = lsu_size;
          sgn_d   = lsu_signed;
          addr_d  = lsu_addr;
          wdata_d = lsu_wdata[15:0];
          err_d   = req_bad;
          if (req_bad) begin
            state_d = S_DONE;
          end else if (lsu_we && (lsu_size == SZ_WORD)) begin
            // Full-word store skips the read; the write word is ready now.
            wr_d    = lsu_wdata;
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (we_q) begin
          case (size_q)
            SZ_BYTE: wr_d = {wdata_q[7:0], data_memory_in_v[23:0]};
            default: wr_d = {wdata_q[15:0], data_memory_in_v[15:0]};
          endcase
          state_d = S_WRITE;
        end else begin
          case (size_q)
            SZ_BYTE: rdata_d = {{24{sgn_q & data_memory_in_v[31]}}, data_memory_in_v[31:24]};
            SZ_HALF: rdata_d = {{16{sgn_q & data_memory_in_v[31]}}, data_memory_in_v[31:16]};
            default: rdata_d = data_memory_in_v;
          endcase
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; address and write data are zero when unused.
  always_comb begin
    lsu_busy          = (state_q != S_IDLE);
    lsu_done          = (state_q == S_DONE);
    lsu_err           = (state_q == S_DONE) && err_q;
    lsu_rdata         = rdata_q;
    data_memory_read  = (state_q == S_READ);
    data_memory_write = (state_q == S_WRITE);
    data_memory_a     = '0;
    data_memory_out_v = '0;
    if ((state_q == S_READ) || (state_q == S_CAPTURE) || (state_q == S_WRITE)) begin
      data_memory_a = addr_q;
    end
    if (state_q == S_WRITE) begin
      data_memory_out_v = wr_q;
    end
  end

endmodule
